bw_sys_evt_cond: RTL and testbench
==================================

// Module: bw_sys_evt_cond
// PURPOSE
//  Event conditioner between the system-level event model (raw warm reset, ext interrupt,
//  temp trigger, clock stretch) and the CIOP pins. Synchronizes each raw event into the
//  jbus_gclk domain, debounces, and enforces minimum warm-reset width. Converts ext
//  interrupt edges into a pending/ack handshake. Optionally keeps saturating event counters.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops per raw input (>=2)
//  DEB_CYCLES   4   consecutive stable cycles required before a debounced level changes (>=1)
//  RST_MIN_CYC  16  minimum low width of warm_rst_l output, jbus_gclk cycles (>=1)
//  CNT_W        8   width of event counters
// PORTS
//  jbus_gclk        in   1      jbus clock; all logic on posedge
//  j_rst            in   1      synchronous reset, active high
//  raw_warm_rst_l   in   1      async warm reset request, active low
//  raw_ext_int_l    in   1      async external interrupt, active low
//  raw_temp_trig    in   1      async temperature trigger, active high
//  raw_clk_stretch  in   1      async clock stretch request, active high
//  int_ack          in   1      clears int_pend (single-cycle pulse)
//  warm_rst_l       out  1      conditioned warm reset to CIOP, active low
//  ext_int_l        out  1      conditioned interrupt to CIOP, = ~int_pend
//  int_pend         out  1      interrupt pending flag
//  temp_trig        out  1      debounced temperature trigger level
//  clk_stretch      out  1      synchronized clock stretch (no debounce)
//  ext_int_cnt      out  CNT_W  count of ext interrupt edges accepted
//  temp_trig_cnt    out  CNT_W  count of temp_trig rising edges
// BEHAVIOUR
//  - Reset (j_rst=1 at posedge): sync chains/debounced levels for *_l inputs = 1, others = 0;
//    warm_rst_l=1, ext_int_l=1, int_pend=0, temp_trig=0, clk_stretch=0, counters=0, FSM=IDLE.
//  - Debounce (warm_rst_l, ext_int_l, temp_trig): per-signal counter; increments each cycle the
//    synchronized value != debounced value, clears when equal. Debounced value flips when
//    counter reaches DEB_CYCLES. Sync-side pulse < DEB_CYCLES cycles is discarded entirely.
//  - Latency: raw step to debounced = SYNC_STAGES+DEB_CYCLES; outputs registered, +1 (7 at default).
//  - clk_stretch: sync chain only, then one output register; latency SYNC_STAGES+1.
//  - Warm reset FSM (output registered from state):
//      IDLE    : warm_rst_l=1; debounced falls -> ASSERT, load hold counter = RST_MIN_CYC-1.
//      ASSERT  : warm_rst_l=0; counter decrements; at 0 -> WAIT_REL.
//      WAIT_REL: warm_rst_l=0; debounced high -> IDLE (warm_rst_l=1 next cycle).
//    Short request is stretched to exactly RST_MIN_CYC low cycles; long request follows input.
//  - Interrupt: debounced ext_int_l falling edge sets int_pend; int_ack clears it. Same-cycle
//    edge and ack: set wins, int_pend stays 1. Ack with int_pend=0: no effect. Edges while FSM
//    != IDLE are ignored and int_pend is forced 0 (warm reset flushes pending interrupt).
//  - Counters saturate at all-ones, no wrap. Cleared only by j_rst, not by warm reset.
//    ext_int_cnt counts only accepted (FSM=IDLE) edges.
//  - j_rst mid-operation (e.g., FSM in ASSERT): immediate return to reset values next cycle.
// CONFIGURATION
//  BW_SYS_EVT_CNT_EN defined: ext_int_cnt/temp_trig_cnt counters built as above.
//  Not defined: no counter flops; ext_int_cnt and temp_trig_cnt tied to 0.
// TESTING
//  1. j_rst 3 cycles, raw inputs idle -> all outputs at reset values, counters 0.
//  2. raw_ext_int_l low 20 cycles -> ext_int_l low 7 cycles after fall, stays low until
//     int_ack; ack -> ext_int_l=1 next cycle; ext_int_cnt=1 (with CNT_EN).
//  3. raw_temp_trig high 3 cycles (< DEB_CYCLES at defaults) -> temp_trig stays 0, cnt 0;
//     high 10 cycles -> temp_trig high for 10 cycles after 7-cycle latency, temp_trig_cnt=1.
//  4. raw_warm_rst_l low 5 cycles -> warm_rst_l low exactly 16 cycles; low 40 cycles ->
//     warm_rst_l low ~40 cycles, rises 7 cycles after raw rises.
//  5. int_pend=1, then new ext_int edge same cycle as int_ack -> int_pend stays 1; ext
//     edge during warm reset -> int_pend 0, count unchanged.
//  6. 300 temp_trig pulses (CNT_W=8) -> temp_trig_cnt=255; j_rst during ASSERT -> warm_rst_l=1
//     next cycle.

Source files
------------

// File: rtl/bw_sys_evt_cond_if.sv
// Event pin bundle between the system event model (master) and the conditioner (slave).
interface bw_sys_evt_cond_if #(
    parameter int CNT_W = 8
);
    logic             raw_warm_rst_l;
    logic             raw_ext_int_l;
    logic             raw_temp_trig;
    logic             raw_clk_stretch;
    logic             int_ack;
    logic             warm_rst_l;
    logic             ext_int_l;
    logic             int_pend;
    logic             temp_trig;
    logic             clk_stretch;
    logic [CNT_W-1:0] ext_int_cnt;
    logic [CNT_W-1:0] temp_trig_cnt;

    modport master (
        output raw_warm_rst_l, raw_ext_int_l, raw_temp_trig, raw_clk_stretch, int_ack,
        input  warm_rst_l, ext_int_l, int_pend, temp_trig, clk_stretch,
        input  ext_int_cnt, temp_trig_cnt
    );

    modport slave (
        input  raw_warm_rst_l, raw_ext_int_l, raw_temp_trig, raw_clk_stretch, int_ack,
        output warm_rst_l, ext_int_l, int_pend, temp_trig, clk_stretch,
        output ext_int_cnt, temp_trig_cnt
    );
endinterface

// File: rtl/bw_sys_evt_cond.sv
// Event conditioner: sync + debounce of raw system events, warm-reset width stretch, interrupt handshake.
// Define BW_SYS_EVT_CNT_EN to build the saturating event counters; otherwise they read as zero.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | warm_rst_l high, interrupts accepted
//  ASSERT   | warm_rst_l low, holding for the minimum width
//  WAIT_REL | warm_rst_l low, minimum met, waiting for request release
module bw_sys_evt_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int RST_MIN_CYC = 16,
    parameter int CNT_W       = 8
) (
    input logic              jbus_gclk,
    input logic              j_rst,
    bw_sys_evt_cond_if.slave evt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int HOLD_W = (RST_MIN_CYC > 1) ? $clog2(RST_MIN_CYC) : 1;

    // bit order: 0 warm reset, 1 ext interrupt, 2 temp trigger, 3 clock stretch
    localparam logic [3:0]        SYNC_RST  = 4'b0011;
    localparam logic [2:0]        DEB_RST   = 3'b011;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_MIN_CYC - 1);

    logic [3:0] raw_vec;
    logic [3:0] sync_out;
    logic [2:0] deb_lvl;

    logic warm_deb;
    logic ext_deb;
    logic temp_deb;
    logic ext_deb_d;
    logic ext_fall;

    logic temp_trig_q;
    logic clk_stretch_q;
    logic int_pend_q;

    state_t             state_q;
    state_t             state_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic               warm_rst_l_o;

    assign raw_vec = {evt.raw_clk_stretch, evt.raw_temp_trig,
                      evt.raw_ext_int_l, evt.raw_warm_rst_l};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_q;

            always_ff @(posedge jbus_gclk) begin
                if (j_rst) begin
                    chain_q <= {SYNC_STAGES{SYNC_RST[g]}};
                end else begin
                    chain_q <= {chain_q[SYNC_STAGES-2:0], raw_vec[g]};
                end
            end

            assign sync_out[g] = chain_q[SYNC_STAGES-1];
        end

        // A mismatch must persist DEB_CYCLES consecutive cycles before the level flips.
        for (g = 0; g < 3; g++) begin : g_deb
            logic [DEB_W-1:0] cnt_q;
            logic             lvl_q;

            always_ff @(posedge jbus_gclk) begin
                if (j_rst) begin
                    cnt_q <= '0;
                    lvl_q <= DEB_RST[g];
                end else if (sync_out[g] != lvl_q) begin
                    if (cnt_q == DEB_LAST) begin
                        cnt_q <= '0;
                        lvl_q <= sync_out[g];
                    end else begin
                        cnt_q <= cnt_q + DEB_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign deb_lvl[g] = lvl_q;
        end
    endgenerate

    assign warm_deb = deb_lvl[0];
    assign ext_deb  = deb_lvl[1];
    assign temp_deb = deb_lvl[2];
    assign ext_fall = ext_deb_d & ~ext_deb;

    always_ff @(posedge jbus_gclk) begin
        if (j_rst) begin
            ext_deb_d     <= 1'b1;
            temp_trig_q   <= 1'b0;
            clk_stretch_q <= 1'b0;
        end else begin
            ext_deb_d     <= ext_deb;
            temp_trig_q   <= temp_deb;
            clk_stretch_q <= sync_out[3];
        end
    end

    // Warm reset flushes any pending interrupt; a new edge beats a same-cycle ack.
    always_ff @(posedge jbus_gclk) begin
        if (j_rst) begin
            int_pend_q <= 1'b0;
        end else if (state_q != IDLE) begin
            int_pend_q <= 1'b0;
        end else if (ext_fall) begin
            int_pend_q <= 1'b1;
        end else if (evt.int_ack) begin
            int_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge jbus_gclk) begin
        if (j_rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // A request already released when the hold expires goes straight back to IDLE,
    // so a short request gives exactly RST_MIN_CYC low cycles.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (!warm_deb) begin
                    state_d = ASSERT;
                    hold_d  = HOLD_LOAD;
                end
            end
            ASSERT: begin
                if (hold_q == '0) begin
                    state_d = warm_deb ? IDLE : WAIT_REL;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            WAIT_REL: begin
                if (warm_deb) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        warm_rst_l_o = (state_q == IDLE);
    end

    assign evt.warm_rst_l  = warm_rst_l_o;
    assign evt.int_pend    = int_pend_q;
    assign evt.ext_int_l   = ~int_pend_q;
    assign evt.temp_trig   = temp_trig_q;
    assign evt.clk_stretch = clk_stretch_q;

`ifdef BW_SYS_EVT_CNT_EN
    logic             int_accept;
    logic             temp_rise;
    logic [CNT_W-1:0] ext_int_cnt_q;
    logic [CNT_W-1:0] temp_trig_cnt_q;

    assign int_accept = ext_fall & (state_q == IDLE);
    assign temp_rise  = temp_deb & ~temp_trig_q;

    always_ff @(posedge jbus_gclk) begin
        if (j_rst) begin
            ext_int_cnt_q   <= '0;
            temp_trig_cnt_q <= '0;
        end else begin
            if (int_accept && (ext_int_cnt_q != '1)) begin
                ext_int_cnt_q <= ext_int_cnt_q + CNT_W'(1);
            end
            if (temp_rise && (temp_trig_cnt_q != '1)) begin
                temp_trig_cnt_q <= temp_trig_cnt_q + CNT_W'(1);
            end
        end
    end

    assign evt.ext_int_cnt   = ext_int_cnt_q;
    assign evt.temp_trig_cnt = temp_trig_cnt_q;
`else
    assign evt.ext_int_cnt   = '0;
    assign evt.temp_trig_cnt = '0;
`endif

endmodule

// File: tb/tb_bw_sys_evt_cond.sv
// Directed bench for bw_sys_evt_cond; expectations are queued as stimulus is driven.
module tb_bw_sys_evt_cond;

`ifdef BW_SYS_EVT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic jbus_gclk = 1'b0;
    logic j_rst;

    bw_sys_evt_cond_if #(.CNT_W(8)) evt ();

    bw_sys_evt_cond #(
        .SYNC_STAGES(2),
        .DEB_CYCLES (4),
        .RST_MIN_CYC(16),
        .CNT_W      (8)
    ) dut (
        .jbus_gclk(jbus_gclk),
        .j_rst    (j_rst),
        .evt      (evt)
    );

    always #5 jbus_gclk = ~jbus_gclk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   ext_edges  = 0;
    int   temp_edges = 0;

    task automatic tick();
        @(posedge jbus_gclk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h required=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) begin
                n_pass++;
            end else begin
                n_fail++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        if (!CNT_EN) return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    initial begin
        j_rst = 1'b1;
        evt.raw_warm_rst_l  = 1'b1;
        evt.raw_ext_int_l   = 1'b1;
        evt.raw_temp_trig   = 1'b0;
        evt.raw_clk_stretch = 1'b0;
        evt.int_ack         = 1'b0;

        // reset values
        push("rst_warm_rst_l", 1);
        push("rst_ext_int_l", 1);
        push("rst_int_pend", 0);
        push("rst_temp_trig", 0);
        push("rst_clk_stretch", 0);
        push("rst_ext_cnt", 0);
        push("rst_temp_cnt", 0);
        repeat (3) tick();
        pop_chk(32'(evt.warm_rst_l));
        pop_chk(32'(evt.ext_int_l));
        pop_chk(32'(evt.int_pend));
        pop_chk(32'(evt.temp_trig));
        pop_chk(32'(evt.clk_stretch));
        pop_chk(32'(evt.ext_int_cnt));
        pop_chk(32'(evt.temp_trig_cnt));
        j_rst = 1'b0;
        repeat (5) tick();
        push("idle_warm_rst_l", 1);
        push("idle_ext_int_l", 1);
        pop_chk(32'(evt.warm_rst_l));
        pop_chk(32'(evt.ext_int_l));

        // clock stretch: sync only, latency 3
        for (int k = 1; k <= 5; k++) push("stretch_lat", (k >= 3) ? 1 : 0);
        evt.raw_clk_stretch = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            pop_chk(32'(evt.clk_stretch));
        end
        evt.raw_clk_stretch = 1'b0;
        repeat (5) tick();

        // ext interrupt: low 20 cycles, pending until ack
        for (int k = 1; k <= 7; k++) push("ext_lat", (k >= 7) ? 0 : 1);
        evt.raw_ext_int_l = 1'b0;
        ext_edges++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            pop_chk(32'(evt.ext_int_l));
        end
        repeat (13) tick();
        evt.raw_ext_int_l = 1'b1;
        repeat (15) tick();
        push("ext_hold", 0);
        push("pend_hold", 1);
        pop_chk(32'(evt.ext_int_l));
        pop_chk(32'(evt.int_pend));
        push("ext_after_ack", 1);
        push("pend_after_ack", 0);
        push("ext_cnt_one", exp_cnt(ext_edges));
        evt.int_ack = 1'b1;
        tick();
        evt.int_ack = 1'b0;
        pop_chk(32'(evt.ext_int_l));
        pop_chk(32'(evt.int_pend));
        pop_chk(32'(evt.ext_int_cnt));
        push("ack_idle_pend", 0);
        evt.int_ack = 1'b1;
        tick();
        evt.int_ack = 1'b0;
        pop_chk(32'(evt.int_pend));

        // temp trigger: 3-cycle glitch dropped
        for (int k = 1; k <= 15; k++) push("temp_short", 0);
        evt.raw_temp_trig = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 3) evt.raw_temp_trig = 1'b0;
            pop_chk(32'(evt.temp_trig));
        end
        push("temp_cnt_short", exp_cnt(temp_edges));
        pop_chk(32'(evt.temp_trig_cnt));

        // temp trigger: 10-cycle pulse passes with 7-cycle latency
        for (int k = 1; k <= 25; k++) push("temp_long", (k >= 7 && k <= 16) ? 1 : 0);
        evt.raw_temp_trig = 1'b1;
        temp_edges++;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 10) evt.raw_temp_trig = 1'b0;
            pop_chk(32'(evt.temp_trig));
        end
        push("temp_cnt_long", exp_cnt(temp_edges));
        pop_chk(32'(evt.temp_trig_cnt));

        // warm reset: 5-cycle request stretched to 16 low cycles
        for (int k = 1; k <= 30; k++) push("warm_short", (k >= 7 && k <= 22) ? 0 : 1);
        evt.raw_warm_rst_l = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 5) evt.raw_warm_rst_l = 1'b1;
            pop_chk(32'(evt.warm_rst_l));
        end

        // warm reset: 40-cycle request followed, release 7 cycles after raw rise
        for (int k = 1; k <= 55; k++) push("warm_long", (k >= 7 && k <= 46) ? 0 : 1);
        evt.raw_warm_rst_l = 1'b0;
        for (int k = 1; k <= 55; k++) begin
            tick();
            if (k == 40) evt.raw_warm_rst_l = 1'b1;
            pop_chk(32'(evt.warm_rst_l));
        end

        // set pending, then a new edge in the same cycle as ack
        for (int k = 1; k <= 7; k++) push("pend_set", (k >= 7) ? 1 : 0);
        evt.raw_ext_int_l = 1'b0;
        ext_edges++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            pop_chk(32'(evt.int_pend));
        end
        repeat (3) tick();
        evt.raw_ext_int_l = 1'b1;
        repeat (10) tick();
        evt.raw_ext_int_l = 1'b0;
        ext_edges++;
        repeat (6) tick();
        push("pend_before_ack", 1);
        pop_chk(32'(evt.int_pend));
        push("pend_edge_vs_ack", 1);
        push("ext_edge_vs_ack", 0);
        push("ext_cnt_three", exp_cnt(ext_edges));
        evt.int_ack = 1'b1;
        tick();
        evt.int_ack = 1'b0;
        pop_chk(32'(evt.int_pend));
        pop_chk(32'(evt.ext_int_l));
        pop_chk(32'(evt.ext_int_cnt));

        // edge during warm reset: ignored, pending flushed
        evt.raw_ext_int_l = 1'b1;
        repeat (12) tick();
        push("pend_pre_warm", 1);
        for (int k = 9; k <= 30; k++) push("pend_flushed", 0);
        push("warm_back_idle", 1);
        push("ext_cnt_unchanged", exp_cnt(ext_edges));
        evt.raw_warm_rst_l = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 5) begin
                evt.raw_warm_rst_l = 1'b1;
                evt.raw_ext_int_l  = 1'b0;
            end
            if (k == 6 || k >= 9) pop_chk(32'(evt.int_pend));
        end
        pop_chk(32'(evt.warm_rst_l));
        pop_chk(32'(evt.ext_int_cnt));
        evt.raw_ext_int_l = 1'b1;
        repeat (12) tick();

        // counter saturation over 300 temp pulses
        for (int p = 0; p < 300; p++) begin
            evt.raw_temp_trig = 1'b1;
            temp_edges++;
            repeat (5) tick();
            evt.raw_temp_trig = 1'b0;
            repeat (5) tick();
        end
        repeat (10) tick();
        push("temp_cnt_sat", exp_cnt(temp_edges));
        push("temp_after_pulses", 0);
        pop_chk(32'(evt.temp_trig_cnt));
        pop_chk(32'(evt.temp_trig));

        // j_rst while ASSERT
        push("warm_in_assert", 0);
        evt.raw_warm_rst_l = 1'b0;
        repeat (10) tick();
        pop_chk(32'(evt.warm_rst_l));
        push("warm_after_jrst", 1);
        push("ext_cnt_after_jrst", 0);
        push("temp_cnt_after_jrst", 0);
        push("pend_after_jrst", 0);
        j_rst = 1'b1;
        evt.raw_warm_rst_l = 1'b1;
        tick();
        pop_chk(32'(evt.warm_rst_l));
        pop_chk(32'(evt.ext_int_cnt));
        pop_chk(32'(evt.temp_trig_cnt));
        pop_chk(32'(evt.int_pend));
        j_rst = 1'b0;
        push("warm_stays_idle", 1);
        repeat (20) tick();
        pop_chk(32'(evt.warm_rst_l));

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d required=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
